// File: rtl/jelly_crc_checker_if.sv
// Valid/ready word stream carrying data and an end-of-frame marker.
// The master drives data/last/valid and the slave drives ready.
interface jelly_crc_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport master (output data, last, valid, input ready);
    modport slave  (input data, last, valid, output ready);
endinterface

// File: rtl/jelly_crc_checker.sv
// Residue-method CRC checker: strips the trailing FCS words and flags the last payload word pass/fail.
// Latency N = CRC_WIDTH/DATA_WIDTH accepted words; s.ready drops while the output register is stalled or cke=0.
// Optional saturating CRC error counter enabled by JELLY_CRC_CHECKER_COUNTER_EN.
module jelly_crc_checker #(
    parameter int                     DATA_WIDTH      = 8,
    parameter int                     CRC_WIDTH       = 32,
    parameter logic [CRC_WIDTH-1:0]   REPRESENTATIONS = 32'hEDB88320,
    parameter logic [CRC_WIDTH-1:0]   RESIDUE         = 32'hDEBB20E3,
    parameter int                     COUNTER_WIDTH   = 16
) (
    input  logic                     reset_n,
    input  logic                     clk,
    input  logic                     cke,
    jelly_crc_checker_if.slave       s,
    jelly_crc_checker_if.master      m,
    output logic                     m_crc_ok,
    output logic                     out_runt,
    output logic [COUNTER_WIDTH-1:0] err_count
);
    localparam int N  = CRC_WIDTH / DATA_WIDTH;
    localparam int FW = $clog2(N + 1);

    logic [CRC_WIDTH-1:0]  crc;
    logic [CRC_WIDTH-1:0]  crc_src;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [DATA_WIDTH-1:0] dly [N];
    logic [FW-1:0]         fill;
    logic [DATA_WIDTH-1:0] m_dat;
    logic                  m_lst;
    logic                  m_vld;
    logic                  accept;
    logic                  full;
    logic                  crc_match;

    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  c_in,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [CRC_WIDTH-1:0] c;
        c = c_in ^ CRC_WIDTH'(d);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c[0] ? ((c >> 1) ^ REPRESENTATIONS) : (c >> 1);
        end
        return c;
    endfunction

    assign s.ready = cke && (!m_vld || m.ready);
    assign accept  = s.valid && s.ready;
    assign full    = (fill == FW'(N));
    assign m.data  = m_dat;
    assign m.last  = m_lst;
    assign m.valid = m_vld;

    always_comb begin
        crc_src   = (fill == '0) ? '1 : crc;
        crc_next  = crc_step(crc_src, s.data);
        crc_match = (crc_next == RESIDUE);
    end

    // dly[0] holds the newest word; once fill reaches N, dly[N-1] is the oldest payload word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc      <= '1;
            fill     <= '0;
            m_dat    <= '0;
            m_lst    <= 1'b0;
            m_vld    <= 1'b0;
            m_crc_ok <= 1'b0;
            out_runt <= 1'b0;
            for (int i = 0; i < N; i++) begin
                dly[i] <= '0;
            end
        end else begin
            out_runt <= 1'b0;
            if (cke) begin
                if (accept) begin
                    for (int i = N - 1; i > 0; i--) begin
                        dly[i] <= dly[i-1];
                    end
                    dly[0] <= s.data;
                    if (s.last) begin
                        fill <= '0;
                        crc  <= '1;
                    end else begin
                        fill <= full ? fill : fill + 1'b1;
                        crc  <= crc_next;
                    end
                    if (full) begin
                        m_vld    <= 1'b1;
                        m_dat    <= dly[N-1];
                        m_lst    <= s.last;
                        m_crc_ok <= s.last && crc_match;
                    end else begin
                        m_vld    <= 1'b0;
                        m_lst    <= 1'b0;
                        m_crc_ok <= 1'b0;
                        out_runt <= s.last;
                    end
                end else if (m.ready) begin
                    m_vld <= 1'b0;
                end
            end
        end
    end

`ifdef JELLY_CRC_CHECKER_COUNTER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (cke && accept && full && s.last && !crc_match && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_jelly_crc_checker.sv
// Directed bench for jelly_crc_checker: frame table plus reset, back-to-back and mid-frame reset sequences.
module tb_jelly_crc_checker;
    localparam int DW = 8;
    localparam int CW = 32;
    localparam int NW = CW / DW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1;
    logic        m_crc_ok;
    logic        out_runt;
    logic [15:0] err_count;

    jelly_crc_checker_if #(.DATA_WIDTH(DW)) s_if ();
    jelly_crc_checker_if #(.DATA_WIDTH(DW)) m_if ();

    jelly_crc_checker #(
        .DATA_WIDTH     (DW),
        .CRC_WIDTH      (CW),
        .REPRESENTATIONS(32'hEDB88320),
        .RESIDUE        (32'hDEBB20E3),
        .COUNTER_WIDTH  (16)
    ) dut (
        .reset_n  (reset_n),
        .clk      (clk),
        .cke      (cke),
        .s        (s_if),
        .m        (m_if),
        .m_crc_ok (m_crc_ok),
        .out_runt (out_runt),
        .err_count(err_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ok;
    } beat_t;

    typedef struct {
        string            name;
        int               len;
        logic [15:0][7:0] w;
        bit               ok;
        int               runt;
        int               err_on;
        bit               bp;
    } vec_t;

    vec_t  vec [7];
    beat_t out_q [$];
    int    checks = 0;
    int    errors = 0;
    int    runt_cnt = 0;
    bit    bp_en = 1'b0;

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_err(input int on);
`ifdef JELLY_CRC_CHECKER_COUNTER_EN
        return on;
`else
        return 0;
`endif
    endfunction

    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records transfers, checks stall stability and s.ready during stalls.
    initial begin : mon
        beat_t prev;
        bit    stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_data", m_if.data, prev.data);
                chk("hold_last", m_if.last, prev.last);
                chk("hold_ok", m_crc_ok, prev.ok);
            end
            if (m_if.valid && !m_if.ready) chk("s_ready_stall", s_if.ready, 1'b0);
            if (out_runt) runt_cnt++;
            if (m_if.valid && m_if.ready && cke) out_q.push_back('{m_if.data, m_if.last, m_crc_ok});
            stalled = m_if.valid && !(m_if.ready && cke);
            prev    = '{m_if.data, m_if.last, m_crc_ok};
        end
    end

    task automatic send_word(input logic [7:0] d, input logic l);
        bit acc;
        bit done;
        done = 1'b0;
        s_if.data  = d;
        s_if.last  = l;
        s_if.valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            acc = s_if.ready;
            @(posedge clk);
            #1;
            done = acc;
        end
        s_if.valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic send_frame(input int v);
        for (int i = 0; i < vec[v].len; i++) send_word(vec[v].w[i], i == vec[v].len - 1);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_payload(input int v, input int base);
        int n;
        n = (vec[v].len > NW) ? vec[v].len - NW : 0;
        for (int k = 0; k < n; k++) begin
            if (base + k < out_q.size()) begin
                chk({vec[v].name, "_data"}, out_q[base+k].data, vec[v].w[k]);
                chk({vec[v].name, "_last"}, out_q[base+k].last, k == n - 1);
                if (k == n - 1) chk({vec[v].name, "_crc_ok"}, out_q[base+k].ok, vec[v].ok);
            end else begin
                checks++;
                errors++;
                $display("FAIL %s_missing: output beat %0d absent, expected 0x%0h", vec[v].name, base + k, vec[v].w[k]);
            end
        end
    endtask

    task automatic run_vec(input int v);
        int n;
        n = (vec[v].len > NW) ? vec[v].len - NW : 0;
        out_q.delete();
        runt_cnt = 0;
        bp_en = vec[v].bp;
        send_frame(v);
        bp_en = 1'b0;
        drain();
        chk({vec[v].name, "_count"}, out_q.size(), n);
        check_payload(v, 0);
        chk({vec[v].name, "_runt"}, runt_cnt, vec[v].runt);
        chk({vec[v].name, "_err_count"}, err_count, exp_err(vec[v].err_on));
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_m_valid"}, m_if.valid, 1'b0);
        chk({nm, "_m_data"}, m_if.data, 8'h00);
        chk({nm, "_m_last"}, m_if.last, 1'b0);
        chk({nm, "_m_crc_ok"}, m_crc_ok, 1'b0);
        chk({nm, "_out_runt"}, out_runt, 1'b0);
        chk({nm, "_err_count"}, err_count, 16'h0000);
    endtask

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        // Frames are stored first word in the low byte; "123456789" carries FCS 0xCBF43926 LSB first.
        vec[0] = '{"good",            13, 128'h000000CB_F4392639_38373635_34333231, 1'b1, 0, 0, 1'b0};
        vec[1] = '{"bad",             13, 128'h000000CB_F4392739_38373635_34333231, 1'b0, 0, 1, 1'b0};
        vec[2] = '{"runt3",            3, 128'h00000000_00000000_00000000_00CCBBAA, 1'b0, 1, 1, 1'b0};
        vec[3] = '{"good_after_runt", 13, 128'h000000CB_F4392639_38373635_34333231, 1'b1, 0, 1, 1'b0};
        vec[4] = '{"good_bp",         13, 128'h000000CB_F4392639_38373635_34333231, 1'b1, 0, 1, 1'b1};
        vec[5] = '{"runt_n_words",     4, 128'h00000000_00000000_00000000_44332211, 1'b0, 1, 1, 1'b0};
        vec[6] = '{"one_word",         5, 128'h00000000_00000000_000000D2_02EF8D00, 1'b1, 0, 1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("s_ready_idle", s_if.ready, 1'b1);
        @(posedge clk);
        #1;
        cke = 1'b0;
        @(negedge clk);
        chk("s_ready_cke0", s_if.ready, 1'b0);
        @(posedge clk);
        #1;
        cke = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(v);

        out_q.delete();
        runt_cnt = 0;
        send_frame(0);
        send_frame(0);
        drain();
        chk("b2b_count", out_q.size(), 18);
        check_payload(0, 0);
        check_payload(0, 9);
        chk("b2b_runt", runt_cnt, 0);
        chk("b2b_err_count", err_count, exp_err(1));

        out_q.delete();
        for (int i = 0; i < 5; i++) send_word(vec[0].w[i], 1'b0);
        chk("pre_reset_m_valid", m_if.valid, 1'b1);
        chk("pre_reset_m_data", m_if.data, 8'h31);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jelly_crc_checker.md
Name: jelly_crc_checker

Overview:
- Receive-side companion to the CRC calculator. Takes a word stream whose final CRC_WIDTH/DATA_WIDTH words of each frame are the transmitted CRC (FCS).
- Checks each frame with the residue method and forwards the payload with the FCS words stripped.
- Flags the last payload word with a pass/fail bit.
- Sits between a link receiver (e.g. an Ethernet MAC byte stream) and a protocol parser.

Parameters:
- DATA_WIDTH, 8: stream word width. CRC_WIDTH must be an integer multiple of it.
- CRC_WIDTH, 32: CRC register width.
- REPRESENTATIONS, 32'hEDB88320: reflected (LSB-first) generator polynomial.
- RESIDUE, 32'hDEBB20E3: expected un-inverted register value after data+FCS are processed.
- COUNTER_WIDTH, 16: width of the error counter (optional feature).

Ports:
- reset_n  in  1  asynchronous active-low reset
- clk  in  1  clock
- cke  in  1  clock enable; all state holds when 0
- s_data  in  DATA_WIDTH  input word
- s_last  in  1  last word of frame (the final FCS word)
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- m_data  out  DATA_WIDTH  payload word
- m_last  out  1  last payload word of frame
- m_crc_ok  out  1  CRC result; meaningful only when m_last=1
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- out_runt  out  1  one-cycle pulse: frame too short, dropped
- err_count  out  COUNTER_WIDTH  saturating count of CRC failures

Behaviour:
- N = CRC_WIDTH/DATA_WIDTH (4 by default). Delay buffer: N-entry shift register plus fill counter 0..N.
- Reset (reset_n=0, async): m_valid=0, m_last=0, m_crc_ok=0, m_data=0, out_runt=0, err_count=0, fill=0, CRC register = all ones.
- Handshake: s_ready = cke && (!m_valid || m_ready). A word is accepted when s_valid && s_ready.
- Output hold rule: m_* stay stable while m_valid && !m_ready.
- CRC update per accepted word, bitwise, DATA_WIDTH iterations: c = c^data; per bit, c = c[0] ? (c>>1)^REPRESENTATIONS : c>>1.
  - Source register is all ones when fill==0 at frame start, otherwise the running CRC.
- Accept with fill<N: word is pushed into the buffer and fill increments. No output; m_valid clears if the previous word was taken.
- Accept with fill==N: the oldest buffered word goes to m_data with m_valid=1 and the new word is pushed. Latency is N accepted words.
- Accept with s_last=1:
  - If fill==N: emit the oldest word with m_last=1 and m_crc_ok=(updated CRC == RESIDUE).
  - If fill<N (frame is N words or fewer): runt. No output, out_runt=1 for one cycle, not counted as a CRC error.
  - In both cases fill returns to 0 and the CRC returns to all ones, so the next frame may start on the next cycle with no bubble.
- FCS byte order: CRC LSB word first, as produced by the calculator's inverted out_crc.
- Frame boundaries come only from s_last. There is no abort input; a reset is the only way to discard a partial frame.
- cke=0: registers hold, s_ready=0, out_runt does not re-pulse.

Optional Feature:
- Macro JELLY_CRC_CHECKER_COUNTER_EN.
- Defined: err_count increments on every m_last word emitted with m_crc_ok=0, counted at acceptance into the output register. It saturates at all ones and clears only on reset.
- Undefined: counter logic is omitted and err_count is tied to 0.

Test Plan:
- Good frame: send "123456789" (0x31..0x39), then FCS 0x26,0x39,0xF4,0xCB with s_last on 0xCB. Required: m outputs 0x31..0x39, m_last on 0x39, m_crc_ok=1, err_count=0.
- Bad frame: same frame with first FCS byte 0x27. Required: same payload, m_crc_ok=0, err_count=1 (macro on) or 0 (macro off).
- Runt: 3 words 0xAA,0xBB,0xCC with s_last on 0xCC. Required: no m_valid, out_runt high exactly one cycle. Then the good frame is sent: checks ok.
- Back-pressure: good frame with m_ready toggled pseudo-randomly. Required: m_data/m_last stable while stalled, s_ready=0 when m_valid&&!m_ready, identical output sequence.
- Back-to-back: two good frames with no idle cycle between s_last and the next word. Required: both end with m_crc_ok=1 and payloads are not mixed.
- Reset mid-frame: reset_n low after 5 words, then the good frame. Required: outputs zero immediately (async), and the following frame is checked ok.
